// File: rtl/isr_imr_multi_pkg.sv
// Shared definitions for the multi-channel interrupt status/mask controller:
// register select codes, per-channel source offsets and sizing helpers.
package isr_imr_pkg;

    typedef enum logic [1:0] {
        REG_ISR  = 2'd0,
        REG_IMR  = 2'd1,
        REG_IVR  = 2'd2,
        REG_RSVD = 2'd3
    } reg_sel_e;

    // Bit offsets of each source inside a channel's 4-bit ISR nibble.
    localparam int SRC_TX     = 0;
    localparam int SRC_RX     = 1;
    localparam int SRC_DBRK   = 2;
    localparam int SRC_AUX    = 3;
    localparam int SRC_PER_CH = 4;

    localparam logic [7:0] IVR_DEFAULT = 8'h0F;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Byte-select width: at least one bit even when only one byte exists.
    function automatic int bsel_width(input int num_ch);
        return (num_ch / 2 > 1) ? clog2_f(num_ch / 2) : 1;
    endfunction

endpackage

// File: rtl/isr_imr_multi_if.sv
// CPU-side register bus of the interrupt controller.
// Access protocol: a register access is framed by cs=1. With rw=1 the read
// data is combinational on data_out with data_oe=1 for as long as cs stays
// high. With rw=0 exactly one write commits on the first cycle of each cs
// assertion. iack=1 requests the interrupt vector and overrides any read.
interface isr_imr_multi_if #(
    parameter int BSEL_W = 1
);
    logic              cs;
    logic              rw;
    logic [1:0]        reg_sel;
    logic [BSEL_W-1:0] byte_sel;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              data_oe;
    logic              iack;

    modport master (
        output cs, rw, reg_sel, byte_sel, data_in, iack,
        input  data_out, data_oe
    );

    modport slave (
        input  cs, rw, reg_sel, byte_sel, data_in, iack,
        output data_out, data_oe
    );
endinterface

// File: rtl/isr_imr_multi_chan_slice.sv
// One channel's four ISR bits: two sampled level sources and two
// edge-latched event sources with write-1-to-clear.
module isr_chan_slice
    import isr_imr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tx_rdy,
    input  logic                  i_rx_rdy,
    input  logic                  i_dbrk_evt,
    input  logic                  i_aux_evt,
    input  logic                  i_w1c_dbrk,
    input  logic                  i_w1c_aux,
    output logic [SRC_PER_CH-1:0] o_isr
);

    logic [SRC_PER_CH-1:0] r_isr;

    // Level bits follow their inputs; event bits latch and a new pulse beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_isr <= '0;
        end else begin
            r_isr[SRC_TX]   <= i_tx_rdy;
            r_isr[SRC_RX]   <= i_rx_rdy;
            r_isr[SRC_DBRK] <= i_dbrk_evt | (r_isr[SRC_DBRK] & ~i_w1c_dbrk);
            r_isr[SRC_AUX]  <= i_aux_evt  | (r_isr[SRC_AUX]  & ~i_w1c_aux);
        end
    end

    assign o_isr = r_isr;

endmodule

// File: rtl/isr_imr.sv
// Top of the multi-channel interrupt controller: register bus decode,
// IMR/IVR storage, IACK vector response and the registered priority encoder.
module isr_imr_multi
    import isr_imr_pkg::*;
#(
    parameter int         NUM_CH       = 2,
    parameter logic [7:0] IVR_RESET    = IVR_DEFAULT,
    parameter bit         IMR_READBACK = 1'b1,
    localparam int        BSEL_W       = bsel_width(NUM_CH),
    localparam int        ID_W         = clog2_f(SRC_PER_CH * NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    isr_imr_multi_if.slave       bus,
    input  logic [NUM_CH-1:0]    tx_rdy,
    input  logic [NUM_CH-1:0]    rx_rdy,
    input  logic [NUM_CH-1:0]    dbrk_evt,
    input  logic [NUM_CH-1:0]    aux_evt,
    output logic                 irq_n,
    output logic [ID_W-1:0]      irq_id,
    output logic                 irq_id_valid
);

    localparam int NUM_BYTES = NUM_CH / 2;
    localparam int NBITS     = SRC_PER_CH * NUM_CH;

    logic              r_cs_d;
    logic [NBITS-1:0]  r_imr;
    logic [7:0]        r_ivr;
    logic              r_irq_n;
    logic [ID_W-1:0]   r_irq_id;
    logic              r_irq_id_valid;

    logic              w_wr_commit;
    logic              w_byte_ok;
    logic [NBITS-1:0]  w_isr;
    logic [NBITS-1:0]  w_pend;
    logic [ID_W-1:0]   w_id;
    logic [NUM_CH-1:0] w_w1c_dbrk;
    logic [NUM_CH-1:0] w_w1c_aux;
    logic [7:0]        w_rd_data;

    // A write commits only on the rising edge of cs, so a held cs writes once.
    assign w_wr_commit = bus.cs & ~r_cs_d & ~bus.rw;

    // Flags whether byte_sel addresses an implemented byte.
    always_comb begin
        w_byte_ok = 1'b0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (bus.byte_sel == BSEL_W'(k)) w_byte_ok = 1'b1;
        end
    end

    // Decodes ISR writes into per-channel clear strobes for the event bits.
    always_comb begin
        w_w1c_dbrk = '0;
        w_w1c_aux  = '0;
        if (w_wr_commit && bus.reg_sel == REG_ISR && w_byte_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.byte_sel == BSEL_W'(c / 2)) begin
                    w_w1c_dbrk[c] = bus.data_in[SRC_PER_CH * (c % 2) + SRC_DBRK];
                    w_w1c_aux[c]  = bus.data_in[SRC_PER_CH * (c % 2) + SRC_AUX];
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        isr_chan_slice u_slice (
            .clk        (clk),
            .rst        (rst),
            .i_tx_rdy   (tx_rdy[c]),
            .i_rx_rdy   (rx_rdy[c]),
            .i_dbrk_evt (dbrk_evt[c]),
            .i_aux_evt  (aux_evt[c]),
            .i_w1c_dbrk (w_w1c_dbrk[c]),
            .i_w1c_aux  (w_w1c_aux[c]),
            .o_isr      (w_isr[SRC_PER_CH*c +: SRC_PER_CH])
        );
    end

    // Holds the cs history plus the IMR and IVR registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_d <= 1'b0;
            r_imr  <= '0;
            r_ivr  <= IVR_RESET;
        end else begin
            r_cs_d <= bus.cs;
            if (w_wr_commit && w_byte_ok) begin
                if (bus.reg_sel == REG_IMR) begin
                    for (int k = 0; k < NUM_BYTES; k++) begin
                        if (bus.byte_sel == BSEL_W'(k)) r_imr[8*k +: 8] <= bus.data_in;
                    end
                end else if (bus.reg_sel == REG_IVR) begin
                    r_ivr <= bus.data_in;
                end
            end
        end
    end

    // Selects the addressed register byte for a read; unknown targets read zero.
    always_comb begin
        w_rd_data = 8'h00;
        if (w_byte_ok) begin
            case (bus.reg_sel)
                REG_ISR: begin
                    for (int k = 0; k < NUM_BYTES; k++) begin
                        if (bus.byte_sel == BSEL_W'(k)) w_rd_data = w_isr[8*k +: 8];
                    end
                end
                REG_IMR: begin
                    if (IMR_READBACK) begin
                        for (int k = 0; k < NUM_BYTES; k++) begin
                            if (bus.byte_sel == BSEL_W'(k)) w_rd_data = r_imr[8*k +: 8];
                        end
                    end
                end
                REG_IVR: w_rd_data = r_ivr;
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    // Drives the data bus: IACK vector first, otherwise a register read.
    always_comb begin
        bus.data_out = 8'h00;
        bus.data_oe  = 1'b0;
        if (bus.iack) begin
            if (!r_irq_n) begin
                bus.data_out = r_ivr;
                bus.data_oe  = 1'b1;
            end
        end else if (bus.cs && bus.rw) begin
            bus.data_out = w_rd_data;
            bus.data_oe  = 1'b1;
        end
    end

    // Finds the lowest-index pending enabled source.
    always_comb begin
        w_pend = w_isr & r_imr;
        w_id   = '0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            if (w_pend[i]) w_id = ID_W'(i);
        end
    end

    // Registers the interrupt request and source ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_n        <= 1'b1;
            r_irq_id       <= '0;
            r_irq_id_valid <= 1'b0;
        end else begin
            r_irq_n        <= ~|w_pend;
            r_irq_id       <= w_id;
            r_irq_id_valid <= |w_pend;
        end
    end

    assign irq_n        = r_irq_n;
    assign irq_id       = r_irq_id;
    assign irq_id_valid = r_irq_id_valid;

endmodule

// File: tb/tb_isr_imr_multi.sv
// Directed bench: a 4-channel controller for the main features and a
// 2-channel, IMR-unreadable instance for out-of-range and readback cases.
module tb_isr_imr_multi;
    import isr_imr_pkg::*;

    logic clk;
    logic rst;

    logic [3:0] tx4, rx4, dbrk4, aux4;
    logic       irq4_n, irq4_valid;
    logic [3:0] irq4_id;

    logic [1:0] tx2, rx2, dbrk2, aux2;
    logic       irq2_n, irq2_valid;
    logic [2:0] irq2_id;

    int n_checks;
    int n_errors;

    isr_imr_multi_if #(.BSEL_W(1)) bus4 ();
    isr_imr_multi_if #(.BSEL_W(1)) bus2 ();

    isr_imr_multi #(.NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .tx_rdy(tx4), .rx_rdy(rx4), .dbrk_evt(dbrk4), .aux_evt(aux4),
        .irq_n(irq4_n), .irq_id(irq4_id), .irq_id_valid(irq4_valid)
    );

    isr_imr_multi #(.NUM_CH(2), .IVR_RESET(8'hA5), .IMR_READBACK(1'b0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .tx_rdy(tx2), .rx_rdy(rx2), .dbrk_evt(dbrk2), .aux_evt(aux2),
        .irq_n(irq2_n), .irq_id(irq2_id), .irq_id_valid(irq2_valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus4_write(input logic [1:0] sel, input logic bsel, input logic [7:0] d);
        bus4.cs = 1'b1; bus4.rw = 1'b0; bus4.reg_sel = sel; bus4.byte_sel = bsel; bus4.data_in = d;
        tick();
        bus4.cs = 1'b0;
        tick();
    endtask

    task automatic bus4_read(input logic [1:0] sel, input logic bsel,
                             output logic [7:0] d, output logic oe);
        bus4.cs = 1'b1; bus4.rw = 1'b1; bus4.reg_sel = sel; bus4.byte_sel = bsel;
        #1;
        d  = bus4.data_out;
        oe = bus4.data_oe;
        bus4.cs = 1'b0; bus4.rw = 1'b0;
    endtask

    task automatic bus2_write(input logic [1:0] sel, input logic bsel, input logic [7:0] d);
        bus2.cs = 1'b1; bus2.rw = 1'b0; bus2.reg_sel = sel; bus2.byte_sel = bsel; bus2.data_in = d;
        tick();
        bus2.cs = 1'b0;
        tick();
    endtask

    task automatic bus2_read(input logic [1:0] sel, input logic bsel, output logic [7:0] d);
        bus2.cs = 1'b1; bus2.rw = 1'b1; bus2.reg_sel = sel; bus2.byte_sel = bsel;
        #1;
        d = bus2.data_out;
        bus2.cs = 1'b0; bus2.rw = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        logic       oe;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (irq4_n !== 1'b1) begin n_errors++; $display("FAIL reset_irq_n got %b exp 1", irq4_n); end
        n_checks++;
        if (irq4_valid !== 1'b0) begin n_errors++; $display("FAIL reset_id_valid got %b exp 0", irq4_valid); end
        n_checks++;
        if (irq4_id !== 4'd0) begin n_errors++; $display("FAIL reset_irq_id got %0d exp 0", irq4_id); end
        n_checks++;
        if (bus4.data_oe !== 1'b0 || bus4.data_out !== 8'h00) begin
            n_errors++; $display("FAIL idle_bus got oe=%b out=%h exp oe=0 out=00", bus4.data_oe, bus4.data_out);
        end
        bus4_read(REG_ISR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h00 || oe !== 1'b1) begin n_errors++; $display("FAIL reset_isr got %h oe=%b exp 00 oe=1", d, oe); end
        bus4_read(REG_IMR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL reset_imr got %h exp 00", d); end
        bus4_read(REG_IVR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h0F) begin n_errors++; $display("FAIL reset_ivr got %h exp 0f", d); end
        bus2_read(REG_IVR, 1'b0, d);
        n_checks++;
        if (d !== 8'hA5) begin n_errors++; $display("FAIL reset_ivr2 got %h exp a5", d); end
        n_checks++;
        if (irq2_n !== 1'b1) begin n_errors++; $display("FAIL reset_irq2_n got %b exp 1", irq2_n); end
    endtask

    task automatic test_level();
        logic [7:0] d;
        logic       oe;
        bus4_write(REG_IMR, 1'b0, 8'h01);
        tx4[0] = 1'b1;
        tick();
        bus4_read(REG_ISR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL level_isr_1clk got %h exp 01", d); end
        n_checks++;
        if (irq4_n !== 1'b1) begin n_errors++; $display("FAIL level_irq_1clk got %b exp 1", irq4_n); end
        tick();
        n_checks++;
        if (irq4_n !== 1'b0 || irq4_id !== 4'd0 || irq4_valid !== 1'b1) begin
            n_errors++; $display("FAIL level_irq_2clk got n=%b id=%0d v=%b exp n=0 id=0 v=1", irq4_n, irq4_id, irq4_valid);
        end
        tx4[0] = 1'b0;
        tick();
        n_checks++;
        if (irq4_n !== 1'b0) begin n_errors++; $display("FAIL level_drop_1clk got %b exp 0", irq4_n); end
        tick();
        n_checks++;
        if (irq4_n !== 1'b1) begin n_errors++; $display("FAIL level_drop_2clk got %b exp 1", irq4_n); end
    endtask

    task automatic test_event();
        logic [7:0] d;
        logic       oe;
        bus4_write(REG_IMR, 1'b0, 8'h04);
        dbrk4[0] = 1'b1;
        tick();
        dbrk4[0] = 1'b0;
        tick(); tick(); tick();
        bus4_read(REG_ISR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h04) begin n_errors++; $display("FAIL event_held got %h exp 04", d); end
        n_checks++;
        if (irq4_n !== 1'b0 || irq4_id !== 4'd2) begin
            n_errors++; $display("FAIL event_irq got n=%b id=%0d exp n=0 id=2", irq4_n, irq4_id);
        end
        // clear it and watch the request drop one cycle after the commit
        bus4.cs = 1'b1; bus4.rw = 1'b0; bus4.reg_sel = REG_ISR; bus4.byte_sel = 1'b0; bus4.data_in = 8'h04;
        tick();
        bus4.cs = 1'b0;
        bus4_read(REG_ISR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL event_w1c got %h exp 00", d); end
        n_checks++;
        if (irq4_n !== 1'b0) begin n_errors++; $display("FAIL event_clr_1clk got %b exp 0", irq4_n); end
        tick();
        n_checks++;
        if (irq4_n !== 1'b1) begin n_errors++; $display("FAIL event_clr_2clk got %b exp 1", irq4_n); end
        // pulse and clear in the same cycle
        dbrk4[0] = 1'b1;
        bus4.cs = 1'b1; bus4.rw = 1'b0; bus4.reg_sel = REG_ISR; bus4.byte_sel = 1'b0; bus4.data_in = 8'h04;
        tick();
        dbrk4[0] = 1'b0;
        bus4.cs = 1'b0;
        tick();
        bus4_read(REG_ISR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h04) begin n_errors++; $display("FAIL event_set_wins got %h exp 04", d); end
        bus4_write(REG_ISR, 1'b0, 8'h04);
        // a W1C of level bits has no effect
        tx4[0] = 1'b1;
        tick();
        bus4_write(REG_ISR, 1'b0, 8'h0F);
        bus4_read(REG_ISR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL event_level_ignores_w1c got %h exp 01", d); end
        tx4[0] = 1'b0;
        tick(); tick();
    endtask

    task automatic test_multi_channel();
        logic [7:0] d;
        logic       oe;
        bus4_write(REG_IMR, 1'b1, 8'h80);
        bus4_write(REG_IMR, 1'b0, 8'h08);
        aux4[3] = 1'b1; aux4[0] = 1'b1;
        tick();
        aux4 = '0;
        bus4_read(REG_ISR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h08) begin n_errors++; $display("FAIL multi_isr_b0 got %h exp 08", d); end
        bus4_read(REG_ISR, 1'b1, d, oe);
        n_checks++;
        if (d !== 8'h80) begin n_errors++; $display("FAIL multi_isr_b1 got %h exp 80", d); end
        tick();
        n_checks++;
        if (irq4_id !== 4'd3 || irq4_valid !== 1'b1 || irq4_n !== 1'b0) begin
            n_errors++; $display("FAIL multi_id_low got id=%0d v=%b n=%b exp id=3 v=1 n=0", irq4_id, irq4_valid, irq4_n);
        end
        bus4_write(REG_ISR, 1'b0, 8'h08);
        n_checks++;
        if (irq4_id !== 4'd15 || irq4_valid !== 1'b1) begin
            n_errors++; $display("FAIL multi_id_high got id=%0d v=%b exp id=15 v=1", irq4_id, irq4_valid);
        end
    endtask

    task automatic test_iack();
        logic [7:0] d;
        logic       oe;
        bus4_write(REG_IVR, 1'b0, 8'h40);
        bus4.iack = 1'b1;
        #1;
        n_checks++;
        if (bus4.data_out !== 8'h40 || bus4.data_oe !== 1'b1) begin
            n_errors++; $display("FAIL iack_vector got out=%h oe=%b exp 40 oe=1", bus4.data_out, bus4.data_oe);
        end
        bus4.cs = 1'b1; bus4.rw = 1'b1; bus4.reg_sel = REG_ISR; bus4.byte_sel = 1'b1;
        #1;
        n_checks++;
        if (bus4.data_out !== 8'h40) begin n_errors++; $display("FAIL iack_over_read got %h exp 40", bus4.data_out); end
        bus4.cs = 1'b0; bus4.rw = 1'b0; bus4.iack = 1'b0;
        bus4_write(REG_ISR, 1'b1, 8'h80);
        n_checks++;
        if (irq4_n !== 1'b1) begin n_errors++; $display("FAIL iack_src_cleared got %b exp 1", irq4_n); end
        bus4.iack = 1'b1;
        #1;
        n_checks++;
        if (bus4.data_oe !== 1'b0 || bus4.data_out !== 8'h00) begin
            n_errors++; $display("FAIL iack_no_irq got out=%h oe=%b exp 00 oe=0", bus4.data_out, bus4.data_oe);
        end
        bus4.iack = 1'b0;
        bus4_read(REG_IVR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h40) begin n_errors++; $display("FAIL ivr_readback got %h exp 40", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       oe;
        logic [7:0] vals [5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus4.cs = 1'b1; bus4.rw = 1'b0; bus4.reg_sel = REG_IMR; bus4.byte_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus4.data_in = vals[i];
            tick();
        end
        bus4.cs = 1'b0;
        tick();
        bus4_read(REG_IMR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h11) begin n_errors++; $display("FAIL held_cs_one_write got %h exp 11", d); end
        bus4_write(REG_IMR, 1'b0, 8'h22);
        bus4_read(REG_IMR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h22) begin n_errors++; $display("FAIL second_access got %h exp 22", d); end
        bus4_write(REG_RSVD, 1'b0, 8'hFF);
        bus4_read(REG_RSVD, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h00 || oe !== 1'b1) begin n_errors++; $display("FAIL rsvd_read got %h oe=%b exp 00 oe=1", d, oe); end
        bus4_read(REG_IMR, 1'b0, d, oe);
        n_checks++;
        if (d !== 8'h22) begin n_errors++; $display("FAIL rsvd_write_ignored got %h exp 22", d); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] d;
        tx2[0] = 1'b1;
        bus2_write(REG_IMR, 1'b1, 8'hFF);
        bus2_write(REG_IVR, 1'b1, 8'h77);
        tick();
        n_checks++;
        if (irq2_n !== 1'b1) begin n_errors++; $display("FAIL oor_imr_ignored got irq_n=%b exp 1", irq2_n); end
        bus2_read(REG_ISR, 1'b1, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL oor_isr_read got %h exp 00", d); end
        bus2_read(REG_ISR, 1'b0, d);
        n_checks++;
        if (d !== 8'h01) begin n_errors++; $display("FAIL ch2_isr_read got %h exp 01", d); end
        bus2_read(REG_IVR, 1'b0, d);
        n_checks++;
        if (d !== 8'hA5) begin n_errors++; $display("FAIL oor_ivr_ignored got %h exp a5", d); end
        bus2_write(REG_IMR, 1'b0, 8'h01);
        n_checks++;
        if (irq2_n !== 1'b0 || irq2_id !== 3'd0 || irq2_valid !== 1'b1) begin
            n_errors++; $display("FAIL ch2_irq got n=%b id=%0d v=%b exp n=0 id=0 v=1", irq2_n, irq2_id, irq2_valid);
        end
        bus2_read(REG_IMR, 1'b0, d);
        n_checks++;
        if (d !== 8'h00) begin n_errors++; $display("FAIL imr_no_readback got %h exp 00", d); end
        tx2[0] = 1'b0;
        tick(); tick();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        tx4 = '0; rx4 = '0; dbrk4 = '0; aux4 = '0;
        tx2 = '0; rx2 = '0; dbrk2 = '0; aux2 = '0;
        bus4.cs = 1'b0; bus4.rw = 1'b0; bus4.reg_sel = 2'd0; bus4.byte_sel = 1'b0;
        bus4.data_in = 8'h00; bus4.iack = 1'b0;
        bus2.cs = 1'b0; bus2.rw = 1'b0; bus2.reg_sel = 2'd0; bus2.byte_sel = 1'b0;
        bus2.data_in = 8'h00; bus2.iack = 1'b0;

        test_reset();
        test_level();
        test_event();
        test_multi_channel();
        test_iack();
        test_back_to_back();
        test_out_of_range();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/isr_imr_multi.md
Name: isr_imr_multi

Overview:
- Parametrised interrupt status/mask controller for a NUM_CH-channel UART; successor to the fixed 2-channel ISR/IMR block.
- Each channel has four interrupt sources:
  - TxRDY: level.
  - RxRDY/FFULL: level.
  - Delta break: edge-latched.
  - Aux event: edge-latched. Ch0 = counter ready, ch1 = input-port change, others spare.
- Adds write-1-to-clear latched bits, IMR readback, an IVR with IACK vector response, and a registered priority-encoded source ID.
- Sits between the CPU bus decode (tri-state at top level) and the per-channel TX/RX logic.

Parameters:
- NUM_CH, 2, channel count; even, 2..8.
- IVR_RESET, 8'h0F, IVR value after reset.
- IMR_READBACK, 1, 1 = IMR readable; 0 = IMR reads 8'h00.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cs  in  1  block select
- rw  in  1  1 = read, 0 = write
- reg_sel  in  2  0 ISR, 1 IMR, 2 IVR, 3 reserved
- byte_sel  in  BSEL_W  byte index; BSEL_W = max(1, clog2(NUM_CH/2))
- data_in  in  8  write data
- data_out  out  8  read/vector data
- data_oe  out  1  drive enable for top-level tri-state
- iack  in  1  interrupt-acknowledge cycle
- tx_rdy  in  NUM_CH  level sources
- rx_rdy  in  NUM_CH  level sources
- dbrk_evt  in  NUM_CH  1-cycle event pulses
- aux_evt  in  NUM_CH  1-cycle event pulses
- irq_n  out  1  active-low interrupt request
- irq_id  out  clog2(4*NUM_CH)  lowest-index pending enabled bit
- irq_id_valid  out  1  irq_id meaningful

Behaviour:
- ISR layout:
  - Bits 4c+0 tx_rdy, 4c+1 rx_rdy, 4c+2 dbrk, 4c+3 aux, for channel c.
  - Byte k holds channels 2k and 2k+1.
  - With NUM_CH=2 this matches the legacy 8-bit layout.
- Level bits: registered copy of the input each clk. 1-cycle latency; not affected by writes.
- Event bits:
  - Set on any cycle the pulse is high.
  - Held until cleared by writing 1 to that ISR bit.
  - Set and clear in the same cycle: set wins.
- Write commit:
  - Occurs on the cycle with cs=1, cs_d=0, rw=0 (cs_d = cs registered).
  - Exactly one write per cs assertion; holding cs does not repeat the write.
  - Effect is visible the next cycle.
- Write targets:
  - ISR: W1C on event bits; level bits ignored.
  - IMR: full byte load.
  - IVR: load.
  - Reserved reg_sel, or byte_sel >= NUM_CH/2: ignored.
- Read:
  - Combinational while cs=1 and rw=1; data_oe=1.
  - Returns ISR byte, IMR byte (or 8'h00 if IMR_READBACK=0), or IVR.
  - Reserved or out-of-range reads return 8'h00.
  - Reads have no side effects.
- IACK:
  - When iack=1 and irq_n=0: data_out=IVR, data_oe=1.
  - When iack=1 and irq_n=1: data_oe=0 (no response).
  - iack has priority over a concurrent cs read.
- Interrupt outputs, registered from ISR & IMR:
  - irq_n <= ~|(ISR & IMR).
  - irq_id <= index of the lowest set bit of ISR & IMR.
  - irq_id_valid <= |(ISR & IMR).
  - Source-input-to-irq_n latency: 2 clk for level sources, 2 clk for event pulses.
- Reset (rst=1 at clk edge):
  - ISR=0, IMR=0, IVR=IVR_RESET, cs_d=0.
  - irq_n=1, irq_id=0, irq_id_valid=0.
  - Event pulses during reset are lost.
  - Reset mid-access aborts the write; the first post-reset cycle with cs=1 counts as a new edge only if cs was sampled low.
- data_out=8'h00 whenever data_oe=0.

Decomposition:
- Package isr_imr_pkg:
  - REG_ISR/REG_IMR/REG_IVR/REG_RSVD codes.
  - SRC_TX=0, SRC_RX=1, SRC_DBRK=2, SRC_AUX=3 offsets; SRC_PER_CH=4.
  - Default IVR value.
  - clog2 helper.
- Sub-module isr_chan_slice: one per channel; holds 4 ISR bits with level sampling, event latch and W1C. Top level handles the bus, IMR/IVR, IACK and the priority encoder.

Test Plan:
- Reset: read ISR/IMR/IVR -> 8'h00, 8'h00, 8'h0F; irq_n=1; irq_id_valid=0.
- Write IMR byte0=8'h01, raise tx_rdy[0] at cycle 0 -> ISR bit0=1 after 1 clk; irq_n=0 and irq_id=0 after 2 clk; drop tx_rdy[0] -> irq_n=1 two clk later.
- IMR=8'h04, pulse dbrk_evt[0] for 1 clk -> ISR=8'h04 held, irq_n=0; write ISR 8'h04 -> bit clears, irq_n=1 two clk later; write coinciding with a new pulse -> bit stays set.
- NUM_CH=4: IMR byte1=8'h80 and byte0=8'h08, pulse aux_evt[3] and aux_evt[0] together -> irq_id=3; after W1C of byte0 bit3 -> irq_id=15.
- Write IVR=8'h40, pending enabled source, iack=1 -> data_out=8'h40, data_oe=1; clear the source, iack=1 -> data_oe=0.
- Hold cs=1, rw=0 with IMR writes for 5 clk while changing data_in -> only the first value is stored; byte_sel out of range write -> no register change, read 8'h00.
